// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC and issues word reads over a req/ack handshake; 1-cycle min fetch latency.
// Backpressure: memory stalls by holding ack low (REQ persists); decode stalls by withholding PC_LdEn (VALID holds).
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        PC_LdEn,
   input  logic        PC_sel,
   input  logic [31:0] Immed,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic        Imem_ack,
   input  logic [31:0] Imem_rdata,
   output logic [31:0] Instr,
   output logic        Instr_valid,
   output logic [31:0] PC,
   output logic        Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        instr_vld_q;
   logic [31:0] next_pc_d;

   // Branch offset is a word count; the shift drops Immed[31:30], matching 32-bit wrap.
   assign next_pc_d = pc_q + 32'd4 + (PC_sel ? {Immed[29:0], 2'b00} : 32'd0);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0;
         instr_vld_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
            end
            REQ: begin
               if (Imem_ack) begin
                  instr_q     <= Imem_rdata;
                  instr_vld_q <= 1'b1;
                  state_q     <= VALID;
               end
            end
            VALID: begin
               if (PC_LdEn) begin
                  pc_q        <= next_pc_d;
                  instr_vld_q <= 1'b0;
                  state_q     <= REQ;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Imem_req    = (state_q == REQ);
   assign Busy        = (state_q == REQ);
   assign Imem_addr   = {pc_q[31:2], 2'b00};
   assign Instr       = instr_q;
   assign Instr_valid = instr_vld_q;
   assign PC          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table plus randomized traffic against a transaction-level model.
module tb_instruction_fetch;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset_n, PC_LdEn, PC_sel, Imem_ack;
   logic [31:0] Immed, Imem_rdata;

   logic        a_req, a_vld, a_busy;
   logic [31:0] a_addr, a_instr, a_pc;
   logic        b_req, b_vld, b_busy;
   logic [31:0] b_addr, b_instr, b_pc;

   localparam logic [31:0] RP_A = 32'h0000_0000;
   localparam logic [31:0] RP_B = 32'hFFFF_FFFC;

   instruction_fetch #(.RESET_PC(RP_A)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .Immed(Immed),
      .Imem_req(a_req), .Imem_addr(a_addr), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
      .Instr(a_instr), .Instr_valid(a_vld), .PC(a_pc), .Busy(a_busy));

   instruction_fetch #(.RESET_PC(RP_B)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .Immed(Immed),
      .Imem_req(b_req), .Imem_addr(b_addr), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
      .Instr(b_instr), .Instr_valid(b_vld), .PC(b_pc), .Busy(b_busy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Transaction-level reference: is a fetch pending, is a word held, and what PC each copy is on.
   bit          m_started;   // 0 only for the one cycle right after reset
   bit          m_holding;   // an instruction word is held for decode
   logic [31:0] m_pc_a, m_pc_b, m_instr;

   task automatic model_step(input logic rst, input logic ld, input logic sel,
                             input logic [31:0] immed, input logic ack, input logic [31:0] rdata);
      if (!rst) begin
         m_started = 0; m_holding = 0;
         m_pc_a = RP_A; m_pc_b = RP_B; m_instr = 32'h0;
      end else if (!m_started) begin
         m_started = 1;
      end else if (!m_holding) begin
         if (ack) begin
            m_instr   = rdata;
            m_holding = 1;
         end
      end else if (ld) begin
         m_pc_a    = m_pc_a + 4 + (sel ? immed * 4 : 0);
         m_pc_b    = m_pc_b + 4 + (sel ? immed * 4 : 0);
         m_holding = 0;
      end
   endtask

   task automatic check_model();
      logic pend;
      pend = m_started && !m_holding;
      check("m_req_a",   {31'h0, a_req},  {31'h0, pend});
      check("m_busy_a",  {31'h0, a_busy}, {31'h0, pend});
      check("m_addr_a",  a_addr,  m_pc_a);
      check("m_pc_a",    a_pc,    m_pc_a);
      check("m_instr_a", a_instr, m_instr);
      check("m_vld_a",   {31'h0, a_vld},  {31'h0, m_holding});
      check("m_pc_b",    b_pc,    m_pc_b);
      check("m_addr_b",  b_addr,  m_pc_b);
      check("m_req_b",   {31'h0, b_req},  {31'h0, pend});
   endtask

   task automatic apply(input logic rst, input logic ld, input logic sel,
                        input logic [31:0] immed, input logic ack, input logic [31:0] rdata);
      Reset_n = rst; PC_LdEn = ld; PC_sel = sel; Immed = immed;
      Imem_ack = ack; Imem_rdata = rdata;
      @(posedge Clk);
      model_step(rst, ld, sel, immed, ack, rdata);
      @(negedge Clk);
      check_model();
   endtask

   typedef struct {
      logic        rst;
      logic        ld;
      logic        sel;
      logic [31:0] immed;
      logic        ack;
      logic [31:0] rdata;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_vld;
      logic        e_req;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic ld, input logic sel, input logic [31:0] immed,
                               input logic ack, input logic [31:0] rdata, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic e_vld, input logic e_req);
      vec_t v;
      v.rst = rst; v.ld = ld; v.sel = sel; v.immed = immed; v.ack = ack; v.rdata = rdata;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_vld = e_vld; v.e_req = e_req;
      return v;
   endfunction

   vec_t tbl[30];

   initial begin
      //             rst ld sel immed          ack rdata          pc          instr          vld req
      tbl[0]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          32'h00, 32'h0,          0, 0);
      tbl[1]  = mk(0, 0, 0, 32'h0,          1, 32'h9999_9999,  32'h00, 32'h0,          0, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          32'h00, 32'h0,          0, 0);
      tbl[3]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h00, 32'h0,          0, 1);
      tbl[4]  = mk(1, 0, 0, 32'h0,          1, 32'h1234_5678,  32'h00, 32'h1234_5678,  1, 0);
      tbl[5]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h04, 32'h1234_5678,  0, 1);
      tbl[6]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h04, 32'h1234_5678,  0, 1);
      tbl[7]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h04, 32'h1234_5678,  0, 1);
      tbl[8]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h04, 32'h1234_5678,  0, 1);
      tbl[9]  = mk(1, 0, 0, 32'h0,          1, 32'hAAAA_0001,  32'h04, 32'hAAAA_0001,  1, 0);
      tbl[10] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h08, 32'hAAAA_0001,  0, 1);
      tbl[11] = mk(1, 0, 0, 32'h0,          1, 32'h11,         32'h08, 32'h11,         1, 0);
      tbl[12] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h0C, 32'h11,         0, 1);
      tbl[13] = mk(1, 0, 0, 32'h0,          1, 32'h22,         32'h0C, 32'h22,         1, 0);
      tbl[14] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h10, 32'h22,         0, 1);
      tbl[15] = mk(1, 0, 0, 32'h0,          1, 32'h33,         32'h10, 32'h33,         1, 0);
      tbl[16] = mk(1, 1, 0, 32'h7,          0, 32'h0,          32'h14, 32'h33,         0, 1);
      tbl[17] = mk(1, 0, 0, 32'h0,          1, 32'h44,         32'h14, 32'h44,         1, 0);
      tbl[18] = mk(1, 1, 1, 32'hFFFF_FFFE,  0, 32'h0,          32'h10, 32'h44,         0, 1);
      tbl[19] = mk(1, 0, 0, 32'h0,          1, 32'h55,         32'h10, 32'h55,         1, 0);
      tbl[20] = mk(1, 1, 1, 32'h3,          0, 32'h0,          32'h20, 32'h55,         0, 1);
      tbl[21] = mk(1, 0, 0, 32'h0,          1, 32'h66,         32'h20, 32'h66,         1, 0);
      tbl[22] = mk(1, 0, 0, 32'h0,          1, 32'hDEAD_DEAD,  32'h20, 32'h66,         1, 0);
      tbl[23] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h24, 32'h66,         0, 1);
      tbl[24] = mk(1, 1, 1, 32'h40,         0, 32'h0,          32'h24, 32'h66,         0, 1);
      tbl[25] = mk(1, 0, 0, 32'h0,          1, 32'h77,         32'h24, 32'h77,         1, 0);
      tbl[26] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h28, 32'h77,         0, 1);
      tbl[27] = mk(0, 0, 0, 32'h0,          1, 32'hBEEF_BEEF,  32'h00, 32'h0,          0, 0);
      tbl[28] = mk(1, 0, 0, 32'h0,          1, 32'hCAFE_CAFE,  32'h00, 32'h0,          0, 1);
      tbl[29] = mk(1, 0, 0, 32'h0,          1, 32'h88,         32'h00, 32'h88,         1, 0);

      Reset_n = 1'b0; PC_LdEn = 1'b0; PC_sel = 1'b0; Immed = 32'h0;
      Imem_ack = 1'b0; Imem_rdata = 32'h0;
      m_started = 0; m_holding = 0; m_pc_a = RP_A; m_pc_b = RP_B; m_instr = 32'h0;
      @(negedge Clk);

      for (int i = 0; i < 30; i++) begin
         apply(tbl[i].rst, tbl[i].ld, tbl[i].sel, tbl[i].immed, tbl[i].ack, tbl[i].rdata);
         check($sformatf("v%0d_pc", i),    a_pc,    tbl[i].e_pc);
         check($sformatf("v%0d_addr", i),  a_addr,  tbl[i].e_pc);
         check($sformatf("v%0d_instr", i), a_instr, tbl[i].e_instr);
         check($sformatf("v%0d_vld", i),   {31'h0, a_vld},  {31'h0, tbl[i].e_vld});
         check($sformatf("v%0d_req", i),   {31'h0, a_req},  {31'h0, tbl[i].e_req});
         check($sformatf("v%0d_busy", i),  {31'h0, a_busy}, {31'h0, tbl[i].e_req});
         if (i == 5) check("wrap_pc_b", b_pc, 32'h0);
         if (i == 28) check("post_rst_addr_b", b_addr, RP_B);
      end

      // Randomized traffic: occasional resets, random stalls on both sides, random branches.
      for (int c = 0; c < 3000; c++) begin
         logic        r, l, s, k;
         logic [31:0] im, rd;
         r  = ($urandom_range(0, 59) != 0);
         l  = ($urandom_range(0, 2) != 0);
         s  = $urandom_range(0, 1) == 1;
         k  = ($urandom_range(0, 2) == 0);
         im = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 15) - 8);
         rd = $urandom;
         apply(r, l, s, im, k, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
